button_pio_db: RTL

BUTTON_PIO_DB -- requirements
Module: button_pio_db

---
 rtl/button_pio_pkg.sv | 18 +
 rtl/button_debounce.sv | 63 ++++++
 rtl/button_pio_db.sv | 122 ++++++++++++
 3 files changed

// File: rtl/button_pio_pkg.sv
// ----------------------------------------------------------------------------
// button_pio_pkg
// Shared definitions for the debounced button PIO: bus widths and the
// word addresses of the register map.
// ----------------------------------------------------------------------------
package button_pio_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DB      = 3'd0;  // debounced inputs, RO
    localparam logic [ADDR_W-1:0] ADDR_SYNC    = 3'd1;  // synchronised raw inputs, RO
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MSK = 3'd2;  // interrupt mask, RW
    localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd3;  // edge capture, RW1C
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd4;  // rising-edge capture enable, RW
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd5;  // falling-edge capture enable, RW

endpackage

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// One-bit synchroniser followed by a stability counter. The debounced output
// only follows the synchronised input after it has disagreed for DB_CYCLES
// consecutive clocks.
//
// Ports
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   din      : raw asynchronous input
//   sync_o   : synchronised input (last synchroniser stage)
//   db_o     : debounced output
// ----------------------------------------------------------------------------
module button_debounce #(
    parameter int   DB_CYCLES   = 50000,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_BIT    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync_o,
    output logic db_o
);

    localparam int                CNT_W  = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_TC = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   db_q, db_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign db_o   = db_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        db_d   = db_q;
        cnt_d  = cnt_q;
        if (sync_o == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            // disagreement has lasted DB_CYCLES clocks: accept the new level
            db_d  = sync_o;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE_BIT}};
            db_q   <= IDLE_BIT;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/button_pio_db.sv
// ----------------------------------------------------------------------------
// button_pio_db
// Debounced button PIO with edge capture and a level interrupt, exposed
// through a small memory-mapped register file.
//
// Ports
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   address    : word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   in_port    : raw asynchronous button inputs
//   readdata   : registered read data (one-cycle latency)
//   irq        : level interrupt, OR of captured edges under the mask
// ----------------------------------------------------------------------------
module button_pio_db
    import button_pio_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               DB_CYCLES   = 50000,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_LEVEL  = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0]  sync_w, db_w;
    logic [WIDTH-1:0]  db_prev_q, db_prev_d;
    logic [WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic [WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [WIDTH-1:0]  rise, fall;
    logic              wr_en;
    logic              unused_wdata;

    // Only the low WIDTH bits of writedata are stored.
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        button_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .IDLE_BIT    (IDLE_LEVEL[i])
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .sync_o  (sync_w[i]),
            .db_o    (db_w[i])
        );
    end

    assign wr_en = chipselect & ~write_n;
    assign rise  = db_w & ~db_prev_q;
    assign fall  = ~db_w & db_prev_q;

    always_comb begin
        db_prev_d  = db_w;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        edge_d     = edge_q;

        if (wr_en) begin
            case (address)
                ADDR_IRQ_MSK: irq_mask_d = writedata[WIDTH-1:0];
                ADDR_RISE_EN: rise_en_d  = writedata[WIDTH-1:0];
                ADDR_FALL_EN: fall_en_d  = writedata[WIDTH-1:0];
                ADDR_EDGE:    edge_d     = edge_q & ~writedata[WIDTH-1:0];
                default:      ;
            endcase
        end
        // Set is applied after the clear so a new edge is never lost.
        edge_d = edge_d | (rise & rise_en_q) | (fall & fall_en_q);

        // Read mux uses current register values, so a read that coincides
        // with a clear returns the pre-clear edge_capture.
        readdata_d = '0;
        case (address)
            ADDR_DB:      readdata_d[WIDTH-1:0] = db_w;
            ADDR_SYNC:    readdata_d[WIDTH-1:0] = sync_w;
            ADDR_IRQ_MSK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE:    readdata_d[WIDTH-1:0] = edge_q;
            ADDR_RISE_EN: readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN: readdata_d[WIDTH-1:0] = fall_en_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_prev_q  <= IDLE_LEVEL;
            irq_mask_q <= '0;
            edge_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '1;
            readdata_q <= '0;
        end else begin
            db_prev_q  <= db_prev_d;
            irq_mask_q <= irq_mask_d;
            edge_q     <= edge_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & irq_mask_q);

endmodule
